// File: rtl/approx_adder_error_sweeper_pkg.sv
// Shared types and width helpers for the approximate-adder error sweeper.
// The widths_ok() rule applies to every instance, not only to the defaults.
package approx_adder_error_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int half_bits(input int in_bits);
        return in_bits / 2;
    endfunction

    function automatic int n_vec(input int in_bits);
        return 1 << in_bits;
    endfunction

    // The adder output must hold the full a+b, so it is one bit wider than an operand.
    function automatic bit widths_ok(input int in_bits, input int out_bits);
        return (in_bits % 2 == 0) && (out_bits == half_bits(in_bits) + 1);
    endfunction

    localparam int DEF_IN_BITS  = 4;
    localparam int DEF_OUT_BITS = 3;
    localparam int DEF_ET       = 3;
    localparam bit DEF_WIDTHS_OK = widths_ok(DEF_IN_BITS, DEF_OUT_BITS);

endpackage

// File: rtl/approx_adder_error_sweeper_if.sv
// Control, status and adder-under-test signals of the error sweeper.
// The master is the host that also owns the adder; the slave is the sweeper.
interface approx_adder_error_sweeper_if #(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 3
);
    logic                         start;
    logic                         abort;
    logic [IN_BITS-1:0]           dut_in;
    logic [OUT_BITS-1:0]          dut_out;
    logic                         busy;
    logic                         done;
    logic                         pass;
    logic [OUT_BITS-1:0]          max_err;
    logic [IN_BITS:0]             err_count;
    logic [OUT_BITS+IN_BITS-1:0]  sum_err;
    logic [IN_BITS-1:0]           first_fail_vec;
    logic                         first_fail_valid;

    modport master (
        output start, abort, dut_out,
        input  dut_in, busy, done, pass, max_err, err_count, sum_err,
               first_fail_vec, first_fail_valid
    );

    modport slave (
        input  start, abort, dut_out,
        output dut_in, busy, done, pass, max_err, err_count, sum_err,
               first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/approx_adder_error_sweeper_err_calc.sv
// Combinational error of one adder response against the exact sum of its vector.
module approx_err_calc
    import approx_adder_error_sweeper_pkg::*;
#(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 3,
    parameter int ET       = 3
) (
    input  logic [IN_BITS-1:0]  vec,
    input  logic [OUT_BITS-1:0] dut_out,
    output logic [OUT_BITS-1:0] exact,
    output logic [OUT_BITS-1:0] err,
    output logic                violate
);
    localparam int HALF = half_bits(IN_BITS);
    localparam logic [31:0] ET_W = 32'(ET);

    logic [HALF-1:0] op_a;
    logic [HALF-1:0] op_b;

    assign op_a  = vec[HALF-1:0];
    assign op_b  = vec[IN_BITS-1:HALF];
    assign exact = OUT_BITS'(op_a) + OUT_BITS'(op_b);

    // Compare first so the subtraction never wraps.
    assign err     = (dut_out >= exact) ? (dut_out - exact) : (exact - dut_out);
    assign violate = (32'(err) > ET_W);
endmodule

// File: rtl/approx_adder_error_sweeper.sv
// Walks every input vector through a combinational approximate adder and
// accumulates max/count/sum of absolute error plus the first ET violation.
module approx_adder_error_sweeper
    import approx_adder_error_sweeper_pkg::*;
#(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 3,
    parameter int ET       = 3
) (
    input logic                          clk,
    input logic                          rst_n,
    approx_adder_error_sweeper_if.slave  bus
);
    state_t state;
    state_t state_nxt;

    logic [IN_BITS-1:0]          vec;
    logic                        drain_cnt;
    logic                        s1_valid;
    logic [IN_BITS-1:0]          s1_vec;
    logic [OUT_BITS-1:0]         s1_out;
    logic                        pass;
    logic [OUT_BITS-1:0]         max_err;
    logic [IN_BITS:0]            err_count;
    logic [OUT_BITS+IN_BITS-1:0] sum_err;
    logic [IN_BITS-1:0]          ff_vec;
    logic                        ff_valid;

    logic [OUT_BITS-1:0] exact;
    logic [OUT_BITS-1:0] err;
    logic                violate;
    logic                busy;
    logic                start_go;
    logic                abort_go;
    logic                last_vec;

    approx_err_calc #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .ET       (ET)
    ) u_err_calc (
        .vec     (s1_vec),
        .dut_out (s1_out),
        .exact   (exact),
        .err     (err),
        .violate (violate)
    );

    assign busy     = (state == ST_SWEEP) || (state == ST_DRAIN);
    assign start_go = !busy && bus.start;
    assign abort_go = busy && bus.abort;
    assign last_vec = (state == ST_SWEEP) && (vec == {IN_BITS{1'b1}});

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (bus.start) state_nxt = ST_SWEEP;
            ST_SWEEP: begin
                if (bus.abort)    state_nxt = ST_IDLE;
                else if (last_vec) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.abort)        state_nxt = ST_IDLE;
                else if (!drain_cnt)  state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            drain_cnt <= 1'b0;
            s1_valid  <= 1'b0;
            s1_vec    <= '0;
            s1_out    <= '0;
            pass      <= 1'b0;
            max_err   <= '0;
            err_count <= '0;
            sum_err   <= '0;
            ff_vec    <= '0;
            ff_valid  <= 1'b0;
        end else if (abort_go || start_go) begin
            vec       <= '0;
            drain_cnt <= 1'b0;
            s1_valid  <= 1'b0;
            s1_vec    <= '0;
            s1_out    <= '0;
            pass      <= 1'b0;
            max_err   <= '0;
            err_count <= '0;
            sum_err   <= '0;
            ff_vec    <= '0;
            ff_valid  <= 1'b0;
        end else begin
            if (state == ST_SWEEP) begin
                s1_valid <= 1'b1;
                s1_vec   <= vec;
                s1_out   <= bus.dut_out;
                vec      <= vec + IN_BITS'(1);
                if (last_vec) drain_cnt <= 1'b1;
            end else begin
                s1_valid <= 1'b0;
            end

            // ff_valid already reflects the last vector by the second drain edge.
            if (state == ST_DRAIN) begin
                if (drain_cnt) drain_cnt <= 1'b0;
                else           pass      <= !ff_valid;
            end

            if (s1_valid) begin
                if (err > max_err) max_err <= err;
                if (err != '0)     err_count <= err_count + (IN_BITS+1)'(1);
                sum_err <= sum_err + (OUT_BITS+IN_BITS)'(err);
                if (violate && !ff_valid) begin
                    ff_vec   <= s1_vec;
                    ff_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.dut_in           = vec;
    assign bus.busy             = busy;
    assign bus.done             = (state == ST_DONE);
    assign bus.pass             = pass;
    assign bus.max_err          = max_err;
    assign bus.err_count        = err_count;
    assign bus.sum_err          = sum_err;
    assign bus.first_fail_vec   = ff_vec;
    assign bus.first_fail_valid = ff_valid;
endmodule

// File: tb/tb_approx_adder_error_sweeper.sv
// Scoreboard bench: each accepted sweep pushes its expected statistics; a
// monitor pops and compares whenever done rises.
module tb_approx_adder_error_sweeper;
    localparam int IB   = 4;
    localparam int OB   = 3;
    localparam int ETV  = 3;
    localparam int NV   = 1 << IB;
    localparam int HALF = IB / 2;
    localparam int LAT  = NV + 2;

    typedef struct {
        int pass;
        int max_err;
        int err_count;
        int sum_err;
        int ffv;
        int ffvec;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   mode = 0;
    int   lut [NV];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_events = 0;
    exp_t sb [$];

    approx_adder_error_sweeper_if #(.IN_BITS(IB), .OUT_BITS(OB)) bus ();

    approx_adder_error_sweeper #(.IN_BITS(IB), .OUT_BITS(OB), .ET(ETV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder under test: 0 exact, 1 constant 1, 2 sum with bit0 forced, else lookup table.
    function automatic int adder_out(input int m, input int v);
        int a, b;
        a = v % (1 << HALF);
        b = v >> HALF;
        case (m)
            0:       return a + b;
            1:       return 1;
            2:       return (a + b) | 1;
            default: return lut[v];
        endcase
    endfunction

    always_comb bus.dut_out = OB'(adder_out(mode, int'(bus.dut_in)));

    function automatic exp_t ref_stats(input int m, input int accept_cyc);
        exp_t e;
        int d;
        e = '{pass: 1, max_err: 0, err_count: 0, sum_err: 0, ffv: 0, ffvec: 0, cyc: accept_cyc + LAT};
        for (int v = 0; v < NV; v++) begin
            d = adder_out(m, v) - ((v % (1 << HALF)) + (v >> HALF));
            if (d < 0) d = -d;
            if (d > e.max_err) e.max_err = d;
            if (d != 0) e.err_count++;
            e.sum_err += d;
            if (d > ETV && e.ffv == 0) begin
                e.ffv   = 1;
                e.ffvec = v;
            end
        end
        e.pass = (e.ffv == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"},      int'(bus.busy), 0);
        check({tag, "_done"},      int'(bus.done), 0);
        check({tag, "_pass"},      int'(bus.pass), 0);
        check({tag, "_max_err"},   int'(bus.max_err), 0);
        check({tag, "_err_count"}, int'(bus.err_count), 0);
        check({tag, "_sum_err"},   int'(bus.sum_err), 0);
        check({tag, "_ffv"},       int'(bus.first_fail_valid), 0);
        check({tag, "_ffvec"},     int'(bus.first_fail_vec), 0);
        check({tag, "_dut_in"},    int'(bus.dut_in), 0);
    endtask

    // Monitor: compare on every rising edge of done.
    initial begin : monitor
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_done = 1'b0;
            end else begin
                if (bus.done && !prev_done) begin
                    done_events++;
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("done_cycle", cyc, e.cyc);
                        check("pass",       int'(bus.pass), e.pass);
                        check("max_err",    int'(bus.max_err), e.max_err);
                        check("err_count",  int'(bus.err_count), e.err_count);
                        check("sum_err",    int'(bus.sum_err), e.sum_err);
                        check("ffv",        int'(bus.first_fail_valid), e.ffv);
                        if (e.ffv != 0) check("ffvec", int'(bus.first_fail_vec), e.ffvec);
                    end
                end
                prev_done = bus.done;
            end
        end
    end

    task automatic pulse_start(input int m, input bit expect_done);
        @(negedge clk);
        mode = m;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (expect_done) sb.push_back(ref_stats(m, cyc));
    endtask

    task automatic wait_done(input string tag);
        int budget;
        budget = LAT + 10;
        @(negedge clk);
        while (!bus.done && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!bus.done) check({tag, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic run(input int m, input string tag);
        pulse_start(m, 1'b1);
        wait_done(tag);
    endtask

    initial begin : stim
        int ev0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int v = 0; v < NV; v++) lut[v] = $urandom_range(0, (1 << OB) - 1);
        #1;
        check_cleared("in_reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_cleared("after_reset");

        run(0, "exact");
        run(1, "const1");
        run(2, "bit0");
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < NV; v++) lut[v] = $urandom_range(0, (1 << OB) - 1);
            run(3, "random");
        end

        // start during a sweep is ignored
        pulse_start(2, 1'b1);
        repeat (4) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done("busy_start");

        // abort in DONE has no effect
        @(negedge clk) bus.abort = 1'b1;
        @(negedge clk) bus.abort = 1'b0;
        check("done_after_abort_in_done", int'(bus.done), 1);

        // restart from DONE: done drops on the acceptance edge
        pulse_start(1, 1'b1);
        check("done_drop_on_restart", int'(bus.done), 0);
        check("busy_on_restart", int'(bus.busy), 1);
        wait_done("restart");

        // abort mid-sweep
        ev0 = done_events;
        pulse_start(1, 1'b0);
        repeat (9) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        check_cleared("after_abort");
        repeat (LAT + 5) @(negedge clk);
        check("no_done_after_abort", done_events - ev0, 0);
        run(1, "post_abort");

        // async reset mid-sweep
        ev0 = done_events;
        pulse_start(2, 1'b0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_cleared("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        check("no_done_after_reset", done_events - ev0, 0);
        run(2, "post_reset");

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
